// File: rtl/game_packet_tx_pkg.sv
// game_packet_tx_pkg: shared game-state types and packet link constants
package game_packet_tx_pkg;
  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } location_t;
  typedef logic [88:0] data_t;
  localparam logic [7:0] PKT_SYNC_BYTE     = 8'hA5;
  localparam int         PKT_PAYLOAD_BYTES = 12;
  localparam int         PKT_BAUD_DIV      = 644;
  function automatic logic [8*PKT_PAYLOAD_BYTES-1:0] pkt_payload(input data_t d, input logic s);
    return {6'b0, s, d};
  endfunction
endpackage

// File: rtl/game_packet_tx_if.sv
// game_packet_tx_if: snapshot strobe inputs and serial-line outputs of the packet transmitter
interface game_packet_tx_if;
  import game_packet_tx_pkg::*;
  data_t data_in;
  logic  scored_in;
  logic  data_in_valid;
  logic  tx_out;
  logic  busy_out;
  logic  packet_done_out;
  modport master(output data_in, scored_in, data_in_valid, input tx_out, busy_out, packet_done_out);
  modport slave(input data_in, scored_in, data_in_valid, output tx_out, busy_out, packet_done_out);
endinterface

// File: rtl/game_packet_tx_uart_byte_tx.sv
// game_packet_tx_uart_byte_tx: 8N1 byte serializer, idle high, LSB first, BAUD_DIV cycles per bit
module game_packet_tx_uart_byte_tx #(
  parameter int BAUD_DIV = 644
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       start_in,
  output logic       tx_out,
  output logic       done_out
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  // bit timing and frame sequencing; a start on the stop bit's last cycle chains the next byte with no gap
  always_comb begin
    tick     = state_q != S_IDLE && cnt_q == CW'(BAUD_DIV - 1);
    done_out = tick && state_q == S_STOP;
    state_d  = start_in ? S_START :
               !tick ? state_q :
               state_q == S_START ? S_DATA :
               state_q == S_DATA ? (bit_q == 3'd7 ? S_STOP : S_DATA) : S_IDLE;
    cnt_d    = (start_in || tick || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    bit_d    = start_in ? 3'd0 : (tick && state_q == S_DATA) ? bit_q + 1'b1 : bit_q;
    shift_d  = start_in ? byte_in : (tick && state_q == S_DATA) ? {1'b0, shift_q[7:1]} : shift_q;
    tx_out   = state_q == S_START ? 1'b0 : state_q == S_DATA ? shift_q[0] : 1'b1;
  end
  // serializer state; reset drops the line high at once
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/game_packet_tx.sv
// game_packet_tx: frames game state as SYNC + 12 payload bytes (+ XOR checksum byte when PACKET_CHECKSUM_EN is defined) with latest-wins buffering
module game_packet_tx
  import game_packet_tx_pkg::*;
#(
  parameter int         BAUD_DIV  = PKT_BAUD_DIV,
  parameter logic [7:0] SYNC_BYTE = PKT_SYNC_BYTE
) (
  input logic             clk_pixel_in,
  input logic             rst_in,
  game_packet_tx_if.slave bus
);
  localparam int PW = 8 * PKT_PAYLOAD_BYTES;
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SEND = 1'b1;
`ifdef PACKET_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'(PKT_PAYLOAD_BYTES + 1);
`else
  localparam logic [3:0] LAST = 4'(PKT_PAYLOAD_BYTES);
`endif
  logic [0:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [PW-1:0] payload_q, payload_d;
  data_t         pend_data_q, pend_data_d;
  logic          pend_scored_q, pend_scored_d;
  logic          pend_valid_q, pend_valid_d;
  logic          done_q, done_d;
  logic          byte_done, last_done, next_byte, start, capture, new_scored;
  logic [7:0]    byte_sel;
  data_t         new_data;
  logic          tx;
`ifdef PACKET_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif
  // packet sequencing, pending merge and byte selection; a strobe on the final cycle feeds the next packet directly
  always_comb begin
    last_done     = byte_done && idx_q == LAST;
    next_byte     = byte_done && !last_done;
    start         = (state_q == STATE_IDLE && bus.data_in_valid) || (last_done && (bus.data_in_valid || pend_valid_q));
    capture       = bus.data_in_valid && state_q == STATE_SEND && !start;
    new_data      = bus.data_in_valid ? bus.data_in : pend_data_q;
    new_scored    = (bus.data_in_valid & bus.scored_in) | pend_scored_q;
    state_d       = start ? STATE_SEND : last_done ? STATE_IDLE : state_q;
    idx_d         = start ? 4'd0 : next_byte ? idx_q + 1'b1 : idx_q;
    payload_d     = start ? pkt_payload(new_data, new_scored) : next_byte ? {8'h00, payload_q[PW-1:8]} : payload_q;
    pend_valid_d  = start ? 1'b0 : capture ? 1'b1 : pend_valid_q;
    pend_scored_d = start ? 1'b0 : capture ? pend_scored_q | bus.scored_in : pend_scored_q;
    pend_data_d   = capture ? bus.data_in : pend_data_q;
    done_d        = last_done;
`ifdef PACKET_CHECKSUM_EN
    byte_sel      = start ? SYNC_BYTE : idx_q == 4'(PKT_PAYLOAD_BYTES) ? csum_q : payload_q[7:0];
    csum_d        = start ? 8'h00 : (next_byte && idx_q != 4'(PKT_PAYLOAD_BYTES)) ? csum_q ^ payload_q[7:0] : csum_q;
`else
    byte_sel      = start ? SYNC_BYTE : payload_q[7:0];
`endif
  end
  // packet-level state; async reset abandons any frame in flight
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= STATE_IDLE;
      idx_q         <= '0;
      payload_q     <= '0;
      pend_data_q   <= '0;
      pend_scored_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      done_q        <= 1'b0;
`ifdef PACKET_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      payload_q     <= payload_d;
      pend_data_q   <= pend_data_d;
      pend_scored_q <= pend_scored_d;
      pend_valid_q  <= pend_valid_d;
      done_q        <= done_d;
`ifdef PACKET_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end
  game_packet_tx_uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_byte_tx (
    .clk_pixel_in(clk_pixel_in),
    .rst_in(rst_in),
    .byte_in(byte_sel),
    .start_in(start || next_byte),
    .tx_out(tx),
    .done_out(byte_done)
  );
  assign bus.tx_out          = tx;
  assign bus.busy_out        = state_q == STATE_SEND;
  assign bus.packet_done_out = done_q;
endmodule

// File: tb/tb_game_packet_tx.sv
// tb_game_packet_tx: randomized bench against a wire-level reference model of the packet transmitter
module tb_game_packet_tx;
  import game_packet_tx_pkg::*;
  localparam int BD = 4;
`ifdef PACKET_CHECKSUM_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif
  localparam int L = NB * 10 * BD;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic line_q[$];
  logic [7:0] rx_q[$];
  logic m_pv = 1'b0;
  logic m_ps = 1'b0;
  logic m_last = 1'b0;
  data_t m_pd = '0;

  game_packet_tx_if bus();
  game_packet_tx #(.BAUD_DIV(BD), .SYNC_BYTE(8'hA5)) dut (
    .clk_pixel_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic data_t rnd();
    return 89'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [7:0] pkt_byte(input data_t d, input logic s, input int k);
    logic [95:0] p;
    logic [7:0] x;
    p = {6'b0, s, d};
    x = 8'h00;
    if (k == 0) return 8'hA5;
    if (k <= 12) return p[8*(k-1) +: 8];
    for (int i = 0; i < 12; i++) x ^= p[8*i +: 8];
    return x;
  endfunction

  task automatic push_packet(input data_t d, input logic s);
    logic [9:0] f;
    for (int k = 0; k < NB; k++) begin
      f = {1'b1, pkt_byte(d, s, k), 1'b0};
      for (int b = 0; b < 10; b++) repeat (BD) line_q.push_back(f[b]);
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    m_pv = 1'b0;
    m_ps = 1'b0;
    m_last = 1'b0;
  endtask

  task automatic cycle(input logic v, input data_t d, input logic s);
    logic exp_tx, exp_busy, last;
    @(negedge clk);
    cyc++;
    exp_busy = line_q.size() > 0;
    last = line_q.size() == 1;
    exp_tx = exp_busy ? line_q.pop_front() : 1'b1;
    checks += 3;
    if (bus.tx_out !== exp_tx) begin
      errors++;
      $display("FAIL tx_wave cyc=%0d got %b exp %b", cyc, bus.tx_out, exp_tx);
    end
    if (bus.busy_out !== exp_busy) begin
      errors++;
      $display("FAIL busy_wave cyc=%0d got %b exp %b", cyc, bus.busy_out, exp_busy);
    end
    if (bus.packet_done_out !== m_last) begin
      errors++;
      $display("FAIL done_wave cyc=%0d got %b exp %b", cyc, bus.packet_done_out, m_last);
    end
    m_last = last;
    bus.data_in_valid = v;
    bus.data_in = d;
    bus.scored_in = s;
    if (last && (v || m_pv)) begin
      push_packet(v ? d : m_pd, (v & s) | m_ps);
      m_pv = 1'b0;
      m_ps = 1'b0;
    end else if (!exp_busy && v) begin
      push_packet(d, s);
    end else if (v) begin
      m_pd = d;
      m_ps = m_ps | s;
      m_pv = 1'b1;
    end
  endtask

  task automatic idle();
    cycle(1'b0, rnd(), 1'($urandom()));
  endtask

  task automatic run(input int n);
    repeat (n) idle();
  endtask

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_out === 1'b0) begin
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = bus.tx_out;
        end
        repeat (BD) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  task automatic test_reset();
    bus.data_in_valid = 1'b0;
    bus.data_in = '0;
    bus.scored_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", bus.tx_out); end
    if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_out); end
    if (bus.packet_done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.packet_done_out); end
    rst = 1'b0;
    model_reset();
    run(5);
  endtask

  task automatic test_single();
    int t0, td;
    logic [7:0] e;
    t0 = -1;
    td = -1;
    rx_q.delete();
    cycle(1'b1, '0, 1'b1);
    repeat (L + 10) begin
      idle();
      if (t0 < 0 && bus.tx_out === 1'b0) t0 = cyc;
      if (td < 0 && bus.packet_done_out === 1'b1) td = cyc;
    end
    checks += 2;
    if (td - t0 != NB * 40) begin errors++; $display("FAIL single_done_delay got %0d exp %0d", td - t0, NB * 40); end
    if (rx_q.size() != NB) begin errors++; $display("FAIL single_len got %0d exp %0d", rx_q.size(), NB); end
    for (int k = 0; k < NB; k++) begin
      e = k == 0 ? 8'hA5 : (k == 12 || k == 13) ? 8'h02 : 8'h00;
      checks++;
      if (rx_q[k] !== e) begin errors++; $display("FAIL single_byte%0d got %h exp %h", k, rx_q[k], e); end
    end
  endtask

  task automatic test_random_packets();
    data_t d;
    logic s;
    for (int n = 0; n < 3; n++) begin
      d = rnd();
      s = 1'($urandom());
      rx_q.delete();
      run(int'($urandom_range(0, 7)));
      cycle(1'b1, d, s);
      run(L + 5);
      checks++;
      if (rx_q.size() != NB) begin errors++; $display("FAIL rand_len got %0d exp %0d", rx_q.size(), NB); end
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (rx_q[k] !== pkt_byte(d, s, k)) begin errors++; $display("FAIL rand_byte%0d got %h exp %h", k, rx_q[k], pkt_byte(d, s, k)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    data_t a, b;
    logic sa, sb, tx_at_d, busy_at_d;
    int off, nd, drops;
    a = rnd();
    b = rnd();
    sa = 1'($urandom());
    sb = 1'($urandom());
    off = int'($urandom_range(10, L - 20));
    nd = 0;
    drops = 0;
    tx_at_d = 1'b1;
    busy_at_d = 1'b0;
    rx_q.delete();
    cycle(1'b1, a, sa);
    for (int i = 1; i < 2 * L + 10; i++) begin
      if (i == off) cycle(1'b1, b, sb); else idle();
      if (bus.packet_done_out === 1'b1) begin
        nd++;
        if (nd == 1) begin tx_at_d = bus.tx_out; busy_at_d = bus.busy_out; end
      end
      if (nd < 2 && bus.busy_out !== 1'b1) drops++;
    end
    checks += 5;
    if (nd != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", nd); end
    if (tx_at_d !== 1'b0) begin errors++; $display("FAIL b2b_start_at_done got %b exp 0", tx_at_d); end
    if (busy_at_d !== 1'b1) begin errors++; $display("FAIL b2b_busy_at_done got %b exp 1", busy_at_d); end
    if (drops != 0) begin errors++; $display("FAIL b2b_busy_drops got %0d exp 0", drops); end
    if (rx_q.size() != 2 * NB) begin errors++; $display("FAIL b2b_len got %0d exp %0d", rx_q.size(), 2 * NB); end
    for (int k = 0; k < NB; k++) begin
      checks += 2;
      if (rx_q[k] !== pkt_byte(a, sa, k)) begin errors++; $display("FAIL b2b_a_byte%0d got %h exp %h", k, rx_q[k], pkt_byte(a, sa, k)); end
      if (rx_q[NB+k] !== pkt_byte(b, sb, k)) begin errors++; $display("FAIL b2b_b_byte%0d got %h exp %h", k, rx_q[NB+k], pkt_byte(b, sb, k)); end
    end
  endtask

  task automatic test_overwrite();
    data_t a, b, c;
    logic sa;
    int o1, o2;
    a = rnd();
    b = rnd();
    c = rnd();
    sa = 1'($urandom());
    o1 = int'($urandom_range(5, L / 2));
    o2 = int'($urandom_range(L / 2 + 1, L - 2));
    rx_q.delete();
    cycle(1'b1, a, sa);
    for (int i = 1; i < 2 * L + 10; i++) begin
      if (i == o1) cycle(1'b1, b, 1'b1);
      else if (i == o2) cycle(1'b1, c, 1'b0);
      else idle();
    end
    checks++;
    if (rx_q.size() != 2 * NB) begin errors++; $display("FAIL ovw_len got %0d exp %0d", rx_q.size(), 2 * NB); end
    for (int k = 0; k < NB; k++) begin
      checks += 2;
      if (rx_q[k] !== pkt_byte(a, sa, k)) begin errors++; $display("FAIL ovw_a_byte%0d got %h exp %h", k, rx_q[k], pkt_byte(a, sa, k)); end
      if (rx_q[NB+k] !== pkt_byte(c, 1'b1, k)) begin errors++; $display("FAIL ovw_c_byte%0d got %h exp %h", k, rx_q[NB+k], pkt_byte(c, 1'b1, k)); end
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    lows = 0;
    cycle(1'b1, rnd(), 1'b1);
    run(5 * 10 * BD + 5 * BD);
    #2;
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b exp 1", bus.tx_out); end
    if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy_out); end
    if (bus.packet_done_out !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.packet_done_out); end
    model_reset();
    run(2);
    rst = 1'b0;
    repeat (2 * L) begin
      idle();
      if (bus.tx_out !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL rstmid_silent got %0d exp 0", lows); end
    rx_q.delete();
  endtask

  task automatic test_coincident();
    data_t a, p, d;
    logic sa, tx_at_d;
    int nd;
    a = rnd();
    p = rnd();
    d = rnd();
    sa = 1'($urandom());
    nd = 0;
    tx_at_d = 1'b1;
    rx_q.delete();
    cycle(1'b1, a, sa);
    for (int i = 1; i < 3 * L; i++) begin
      if (i == L / 3) cycle(1'b1, p, 1'b1);
      else if (i == L) cycle(1'b1, d, 1'b0);
      else idle();
      if (bus.packet_done_out === 1'b1) begin
        nd++;
        if (nd == 1) tx_at_d = bus.tx_out;
      end
    end
    checks += 3;
    if (nd != 2) begin errors++; $display("FAIL coin_done_count got %0d exp 2", nd); end
    if (tx_at_d !== 1'b0) begin errors++; $display("FAIL coin_start_at_done got %b exp 0", tx_at_d); end
    if (rx_q.size() != 2 * NB) begin errors++; $display("FAIL coin_len got %0d exp %0d", rx_q.size(), 2 * NB); end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (rx_q[NB+k] !== pkt_byte(d, 1'b1, k)) begin errors++; $display("FAIL coin_byte%0d got %h exp %h", k, rx_q[NB+k], pkt_byte(d, 1'b1, k)); end
    end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) cycle(1'b1, rnd(), 1'($urandom()));
      else idle();
    end
    run(line_q.size() + 5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_packets();
    test_back_to_back();
    test_overwrite();
    test_reset_mid();
    test_coincident();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
